// File: rtl/mdc_delay_commutator.sv
// Delay-switch-delay commutator for one stage of an MDC FFT pipeline.
// Optional start-of-block output out_sop is enabled by defining MDC_COMM_SOP_EN.
module mdc_delay_commutator #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DELAY = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_clr,
    input  logic                    bypass,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_up_re,
    input  logic signed [WIDTH-1:0] in_up_im,
    input  logic signed [WIDTH-1:0] in_low_re,
    input  logic signed [WIDTH-1:0] in_low_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_up_re,
    output logic signed [WIDTH-1:0] out_up_im,
    output logic signed [WIDTH-1:0] out_low_re,
    output logic signed [WIDTH-1:0] out_low_im
`ifdef MDC_COMM_SOP_EN
    ,
    output logic                    out_sop
`endif
);

    localparam int unsigned CNT_W = $clog2(DELAY) + 1;
    localparam int unsigned DW    = 2 * WIDTH;

    if (DELAY < 1 || DELAY > 16 || (DELAY & (DELAY - 1)) != 0) begin : g_bad_delay
        $error("mdc_delay_commutator: DELAY must be a power of two in 1..16");
    end

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] prime_q, prime_d;
    logic [DW-1:0]    low_dl_q [DELAY];
    logic [DW-1:0]    low_dl_d [DELAY];
    logic [DW-1:0]    up_dl_q  [DELAY];
    logic [DW-1:0]    up_dl_d  [DELAY];
    logic [DW-1:0]    up_out_q,  up_out_d;
    logic [DW-1:0]    low_out_q, low_out_d;
    logic             valid_q,   valid_d;
`ifdef MDC_COMM_SOP_EN
    logic             sop_q,     sop_d;
`endif

    logic [DW-1:0] in_up_c, in_low_c;
    logic [DW-1:0] ld_c, p_c, q_c;
    logic          sel_c, primed_c;

    // Switch stage: sel picks whether the delayed lower sample goes up or down.
    always_comb begin
        in_up_c  = {in_up_re, in_up_im};
        in_low_c = {in_low_re, in_low_im};
        ld_c     = low_dl_q[DELAY-1];
        sel_c    = cnt_q[CNT_W-1];
        p_c      = sel_c ? ld_c : in_up_c;
        q_c      = sel_c ? in_up_c : ld_c;
        primed_c = (prime_q == CNT_W'(DELAY));
    end

    // Next-state: sync_clr beats bypass beats a normal accepted sample.
    always_comb begin
        cnt_d     = cnt_q;
        prime_d   = prime_q;
        low_dl_d  = low_dl_q;
        up_dl_d   = up_dl_q;
        up_out_d  = up_out_q;
        low_out_d = low_out_q;
        valid_d   = 1'b0;
`ifdef MDC_COMM_SOP_EN
        sop_d     = 1'b0;
`endif
        if (sync_clr) begin
            cnt_d   = '0;
            prime_d = '0;
        end else if (bypass) begin
            cnt_d   = '0;
            prime_d = '0;
            if (in_valid) begin
                up_out_d  = in_up_c;
                low_out_d = in_low_c;
                valid_d   = 1'b1;
`ifdef MDC_COMM_SOP_EN
                sop_d     = 1'b1;
`endif
            end
        end else if (in_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!primed_c) begin
                prime_d = prime_q + CNT_W'(1);
            end
            low_dl_d[0] = in_low_c;
            up_dl_d[0]  = p_c;
            for (int unsigned i = 1; i < DELAY; i++) begin
                low_dl_d[i] = low_dl_q[i-1];
                up_dl_d[i]  = up_dl_q[i-1];
            end
            // Until DELAY samples are in, the lines still hold pre-restart data.
            if (primed_c) begin
                up_out_d  = up_dl_q[DELAY-1];
                low_out_d = q_c;
                valid_d   = 1'b1;
`ifdef MDC_COMM_SOP_EN
                sop_d     = (cnt_q == CNT_W'(DELAY));
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            prime_q   <= '0;
            low_dl_q  <= '{default: '0};
            up_dl_q   <= '{default: '0};
            up_out_q  <= '0;
            low_out_q <= '0;
            valid_q   <= 1'b0;
`ifdef MDC_COMM_SOP_EN
            sop_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            prime_q   <= prime_d;
            low_dl_q  <= low_dl_d;
            up_dl_q   <= up_dl_d;
            up_out_q  <= up_out_d;
            low_out_q <= low_out_d;
            valid_q   <= valid_d;
`ifdef MDC_COMM_SOP_EN
            sop_q     <= sop_d;
`endif
        end
    end

    assign out_valid  = valid_q;
    assign out_up_re  = up_out_q[DW-1:WIDTH];
    assign out_up_im  = up_out_q[WIDTH-1:0];
    assign out_low_re = low_out_q[DW-1:WIDTH];
    assign out_low_im = low_out_q[WIDTH-1:0];
`ifdef MDC_COMM_SOP_EN
    assign out_sop    = sop_q;
`endif

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Bench for mdc_delay_commutator: DELAY = 1, 2, 4 instances share stimulus and
// are checked against an index-based model of the output ordering.
module tb_mdc_delay_commutator;

    localparam int unsigned W  = 9;
    localparam int unsigned NI = 3;
    localparam int unsigned HN = 4096;

    logic clk, rst, sync_clr, bypass, in_valid;
    logic signed [W-1:0] in_up_re, in_up_im, in_low_re, in_low_im;

    logic signed [W-1:0] o_ure [NI];
    logic signed [W-1:0] o_uim [NI];
    logic signed [W-1:0] o_lre [NI];
    logic signed [W-1:0] o_lim [NI];
    logic                o_vld [NI];
    logic                o_sop [NI];

    logic [2*W-1:0] e_up  [NI];
    logic [2*W-1:0] e_low [NI];
    logic           e_vld [NI];
    logic           e_sop [NI];
    logic [2*W-1:0] uph [NI][HN];
    logic [2*W-1:0] lwh [NI][HN];
    int             mn  [NI];

    int vectors;
    int miscompares;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mdc_delay_commutator #(.WIDTH(W), .DELAY(1 << g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sync_clr   (sync_clr),
            .bypass     (bypass),
            .in_valid   (in_valid),
            .in_up_re   (in_up_re),
            .in_up_im   (in_up_im),
            .in_low_re  (in_low_re),
            .in_low_im  (in_low_im),
            .out_valid  (o_vld[g]),
            .out_up_re  (o_ure[g]),
            .out_up_im  (o_uim[g]),
            .out_low_re (o_lre[g]),
            .out_low_im (o_lim[g])
`ifdef MDC_COMM_SOP_EN
            ,
            .out_sop    (o_sop[g])
`endif
        );
`ifndef MDC_COMM_SOP_EN
        assign o_sop[g] = 1'b0;
`endif
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rnd();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic drive(input logic v, input int ur, input int ui, input int lr, input int li);
        in_valid  = v;
        in_up_re  = W'(ur);
        in_up_im  = W'(ui);
        in_low_re = W'(lr);
        in_low_im = W'(li);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mn[i]    = 0;
            e_up[i]  = '0;
            e_low[i] = '0;
            e_vld[i] = 1'b0;
            e_sop[i] = 1'b0;
        end
    endtask

    // Expected outputs after one clock edge, from sample indices since restart.
    task automatic model_edge();
        int d, n, k, m;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            d = 1 << i;
            n = mn[i];
            if (sync_clr) begin
                mn[i]    = 0;
                e_vld[i] = 1'b0;
            end else if (bypass) begin
                mn[i]    = 0;
                e_vld[i] = in_valid;
                if (in_valid) begin
                    e_up[i]  = {in_up_re, in_up_im};
                    e_low[i] = {in_low_re, in_low_im};
                end
            end else if (in_valid) begin
                if (n >= int'(HN)) begin
                    $display("FAIL model_depth: history index %0d exceeds %0d", n, HN);
                    $fatal(1);
                end
                uph[i][n] = {in_up_re, in_up_im};
                lwh[i][n] = {in_low_re, in_low_im};
                if (n >= d) begin
                    k = n % (2 * d);
                    m = n - d;
                    e_low[i] = (k < d) ? lwh[i][n-d] : uph[i][n];
                    e_up[i]  = ((m % (2 * d)) < d) ? uph[i][m] : lwh[i][m-d];
                    e_vld[i] = 1'b1;
                end else begin
                    e_vld[i] = 1'b0;
                end
                mn[i] = n + 1;
            end else begin
                e_vld[i] = 1'b0;
            end
`ifdef MDC_COMM_SOP_EN
            e_sop[i] = !sync_clr && in_valid && (bypass || (n >= d && (n % (2 * d)) == d));
`else
            e_sop[i] = 1'b0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sync_clr = 1'b0; bypass = 1'b0;
        drive(1'b1, 3, 3, 4, 4);
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== 38'd0) begin
                miscompares++;
                $display("FAIL reset D=%0d: got v=%b up=%0d/%0d low=%0d/%0d, exp all zero",
                         1 << i, o_vld[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed_d1();
        int eu[5] = '{0, 1, 11, 3, 13};
        int el[5] = '{0, 2, 12, 4, 14};
        logic ev[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        sync_clr = 1'b1; drive(1'b1, 0, 0, 0, 0); tick(); sync_clr = 1'b0;
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, s + 1, s + 1, s + 11, s + 11);
            tick();
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== {e_vld[i], e_sop[i], e_up[i], e_low[i]}) begin
                    miscompares++;
                    $display("FAIL d1_model D=%0d t=%0t: got v=%b s=%b up=%0d/%0d low=%0d/%0d exp v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             1 << i, $time, o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i],
                             e_vld[i], e_sop[i], $signed(e_up[i][2*W-1:W]), $signed(e_up[i][W-1:0]),
                             $signed(e_low[i][2*W-1:W]), $signed(e_low[i][W-1:0]));
                end
            end
            vectors++;
            if (o_vld[0] !== ev[s] || (ev[s] && (o_ure[0] !== W'(eu[s]) || o_lim[0] !== W'(el[s])))) begin
                miscompares++;
                $display("FAIL d1_table s=%0d: got v=%b up=%0d low=%0d exp v=%b up=%0d low=%0d",
                         s, o_vld[0], o_ure[0], o_lim[0], ev[s], eu[s], el[s]);
            end
        end
    endtask

    task automatic test_directed_d2();
        int eu[10] = '{0, 0, 1, 2, 21, 22, 5, 6, 25, 26};
        int el[10] = '{0, 0, 3, 4, 23, 24, 7, 8, 27, 28};
        logic es[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic ev;
        sync_clr = 1'b1; drive(1'b1, 0, 0, 0, 0); tick(); sync_clr = 1'b0;
        for (int s = 0; s < 10; s++) begin
            drive(1'b1, s + 1, s + 1, s + 21, s + 21);
            tick();
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== {e_vld[i], e_sop[i], e_up[i], e_low[i]}) begin
                    miscompares++;
                    $display("FAIL d2_model D=%0d t=%0t: got v=%b s=%b up=%0d/%0d low=%0d/%0d exp v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             1 << i, $time, o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i],
                             e_vld[i], e_sop[i], $signed(e_up[i][2*W-1:W]), $signed(e_up[i][W-1:0]),
                             $signed(e_low[i][2*W-1:W]), $signed(e_low[i][W-1:0]));
                end
            end
            ev = (s >= 2);
            vectors++;
            if (o_vld[1] !== ev || (ev && (o_ure[1] !== W'(eu[s]) || o_lre[1] !== W'(el[s])))) begin
                miscompares++;
                $display("FAIL d2_table s=%0d: got v=%b up=%0d low=%0d exp v=%b up=%0d low=%0d",
                         s, o_vld[1], o_ure[1], o_lre[1], ev, eu[s], el[s]);
            end
`ifdef MDC_COMM_SOP_EN
            vectors++;
            if (o_sop[1] !== es[s]) begin
                miscompares++;
                $display("FAIL d2_sop s=%0d: got %b exp %b", s, o_sop[1], es[s]);
            end
`else
            if (es[s]) ev = 1'b0;
`endif
        end
    endtask

    task automatic test_gaps();
        int nvalid = 0;
        sync_clr = 1'b1; drive(1'b1, 0, 0, 0, 0); tick(); sync_clr = 1'b0;
        for (int c = 0; c < 48; c++) begin
            drive((c % 2) == 0, rnd(), rnd(), rnd(), rnd());
            tick();
            if (o_vld[2]) nvalid++;
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== {e_vld[i], e_sop[i], e_up[i], e_low[i]}) begin
                    miscompares++;
                    $display("FAIL gaps D=%0d t=%0t: got v=%b s=%b up=%0d/%0d low=%0d/%0d exp v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             1 << i, $time, o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i],
                             e_vld[i], e_sop[i], $signed(e_up[i][2*W-1:W]), $signed(e_up[i][W-1:0]),
                             $signed(e_low[i][2*W-1:W]), $signed(e_low[i][W-1:0]));
                end
            end
        end
        vectors++;
        if (nvalid != 20) begin
            miscompares++;
            $display("FAIL gaps_count: got %0d valid outputs for D=4, exp 20", nvalid);
        end
    endtask

    task automatic test_async_reset();
        sync_clr = 1'b1; drive(1'b1, 0, 0, 0, 0); tick(); sync_clr = 1'b0;
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, rnd(), rnd(), rnd(), rnd());
            tick();
        end
        drive(1'b1, rnd(), rnd(), rnd(), rnd());
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== 38'd0) begin
                miscompares++;
                $display("FAIL async_rst D=%0d: got v=%b up=%0d/%0d low=%0d/%0d, exp all zero",
                         1 << i, o_vld[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, rnd(), rnd(), rnd(), rnd());
            tick();
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== {e_vld[i], e_sop[i], e_up[i], e_low[i]}) begin
                    miscompares++;
                    $display("FAIL async_rst_prime D=%0d t=%0t: got v=%b s=%b up=%0d/%0d low=%0d/%0d exp v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             1 << i, $time, o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i],
                             e_vld[i], e_sop[i], $signed(e_up[i][2*W-1:W]), $signed(e_up[i][W-1:0]),
                             $signed(e_low[i][2*W-1:W]), $signed(e_low[i][W-1:0]));
                end
            end
        end
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        drive(1'b1, 5, 5, -7, -7);
        tick();
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (o_vld[i] !== 1'b1 || o_ure[i] !== 9'sd5 || o_uim[i] !== 9'sd5 ||
                o_lre[i] !== -9'sd7 || o_lim[i] !== -9'sd7) begin
                miscompares++;
                $display("FAIL bypass_const D=%0d: got v=%b up=%0d/%0d low=%0d/%0d exp v=1 up=5/5 low=-7/-7",
                         1 << i, o_vld[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]);
            end
        end
        for (int c = 0; c < 24; c++) begin
            if (c == 8) bypass = 1'b0;
            drive(c >= 8 || $urandom_range(0, 1) == 1, rnd(), rnd(), rnd(), rnd());
            tick();
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== {e_vld[i], e_sop[i], e_up[i], e_low[i]}) begin
                    miscompares++;
                    $display("FAIL bypass D=%0d t=%0t: got v=%b s=%b up=%0d/%0d low=%0d/%0d exp v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             1 << i, $time, o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i],
                             e_vld[i], e_sop[i], $signed(e_up[i][2*W-1:W]), $signed(e_up[i][W-1:0]),
                             $signed(e_low[i][2*W-1:W]), $signed(e_low[i][W-1:0]));
                end
            end
            if (c >= 8 && c < 12) begin
                vectors++;
                if (o_vld[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bypass_reprime c=%0d: got out_valid=%b exp 0 for D=4", c, o_vld[2]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            sync_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) bypass = ~bypass;
            drive($urandom_range(0, 3) != 0, rnd(), rnd(), rnd(), rnd());
            tick();
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if ({o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i]} !== {e_vld[i], e_sop[i], e_up[i], e_low[i]}) begin
                    miscompares++;
                    $display("FAIL random D=%0d t=%0t: got v=%b s=%b up=%0d/%0d low=%0d/%0d exp v=%b s=%b up=%0d/%0d low=%0d/%0d",
                             1 << i, $time, o_vld[i], o_sop[i], o_ure[i], o_uim[i], o_lre[i], o_lim[i],
                             e_vld[i], e_sop[i], $signed(e_up[i][2*W-1:W]), $signed(e_up[i][W-1:0]),
                             $signed(e_low[i][2*W-1:W]), $signed(e_low[i][W-1:0]));
                end
            end
        end
        sync_clr = 1'b0;
        bypass   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        sync_clr = 1'b0;
        bypass   = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_directed_d1();
        test_directed_d2();
        test_gaps();
        test_async_reset();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
